// File: rtl/mbscore_vic.sv
// Vectored interrupt controller for MBScore: synchronised sources, per-source edge/level
// latching, masking, fixed priority with nesting, redirect at an instruction boundary.
module mbscore_vic #(
    parameter int                    NUM_IRQ    = 8,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 32'h0000_0400,
    parameter int                    VEC_SHIFT  = 2,
    parameter logic [NUM_IRQ-1:0]    EDGE_RESET = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  int_en_n,
    input  logic                  stop,
    input  logic                  eoi,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [NUM_IRQ-1:0]    cfg_wdata,
    output logic [NUM_IRQ-1:0]    cfg_rdata,
    output logic                  int_jump,
    output logic                  setINTR,
    output logic [ADDR_WIDTH-1:0] int_addr,
    output logic [4:0]            int_id
);

    typedef enum logic [1:0] {IDLE, ARM, TAKE} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic [NUM_IRQ-1:0] mask_reg, edge_reg, pend_reg, active_reg;
    logic [NUM_IRQ-1:0] pending, below, eligible;
    logic [NUM_IRQ-1:0] eoi_clear, take_bit, w1c, edge_chg, rise;
    logic [NUM_IRQ-1:0] pend_next, active_next;
    logic [4:0]         win_idx;
    logic               any_elig;
    logic               seen;

    assign pending = (edge_reg & pend_reg) | (~edge_reg & s2);

    // below[i]: no active handler at priority i or higher, i.e. i is under the threshold
    always_comb begin
        seen  = 1'b0;
        below = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            seen     = seen | active_reg[i];
            below[i] = ~seen;
        end
    end

    assign eligible = pending & mask_reg & below;
    assign any_elig = |eligible;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = 5'(i);
        end
    end

    always_comb begin
        take_bit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            take_bit[i] = (state == TAKE) && (int_id == 5'(i));
        end
    end

    assign eoi_clear = eoi ? (active_reg & (~active_reg + NUM_IRQ'(1))) : '0;
    assign w1c       = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : '0;
    assign edge_chg  = (cfg_we && cfg_addr == 2'd1) ? (edge_reg ^ cfg_wdata) : '0;
    assign rise      = s2 & ~s3 & edge_reg;

    // A new edge beats any clear landing in the same cycle
    assign pend_next   = (pend_reg & ~(w1c | edge_chg | take_bit)) | rise;
    // The bit being taken is added after eoi clears, so eoi during TAKE hits the older handler
    assign active_next = (active_reg & ~eoi_clear) | take_bit;

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = mask_reg;
            2'd1:    cfg_rdata = edge_reg;
            2'd2:    cfg_rdata = pending;
            default: cfg_rdata = active_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            mask_reg   <= '0;
            edge_reg   <= EDGE_RESET;
            pend_reg   <= '0;
            active_reg <= '0;
        end else begin
            s1         <= irq;
            s2         <= s1;
            s3         <= s2;
            pend_reg   <= pend_next;
            active_reg <= active_next;
            if (cfg_we && cfg_addr == 2'd0) mask_reg <= cfg_wdata;
            if (cfg_we && cfg_addr == 2'd1) edge_reg <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            int_jump <= 1'b0;
            setINTR  <= 1'b0;
            int_addr <= VEC_BASE;
            int_id   <= '0;
        end else begin
            int_jump <= 1'b0;
            setINTR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig && !int_en_n) state <= ARM;
                end
                ARM: begin
                    if (!any_elig || int_en_n) begin
                        state <= IDLE;
                    end else if (stop) begin
                        state    <= TAKE;
                        int_jump <= 1'b1;
                        setINTR  <= 1'b1;
                        int_id   <= win_idx;
                        int_addr <= VEC_BASE + (ADDR_WIDTH'(win_idx) << VEC_SHIFT);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbscore_vic.sv
// Directed bench for mbscore_vic: register table plus hand-built interrupt scenarios.
module tb_mbscore_vic;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic         int_en_n = 1'b1;
    logic         stop = 1'b0;
    logic         eoi = 1'b0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_addr = '0;
    logic [N-1:0] cfg_wdata = '0;
    logic [N-1:0] cfg_rdata;
    logic         int_jump;
    logic         setINTR;
    logic [31:0]  int_addr;
    logic [4:0]   int_id;

    int n_checks = 0;
    int n_fail   = 0;

    mbscore_vic #(
        .NUM_IRQ(N), .ADDR_WIDTH(32), .VEC_BASE(32'h0000_0400), .VEC_SHIFT(2), .EDGE_RESET('1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .int_en_n(int_en_n), .stop(stop), .eoi(eoi),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_jump(int_jump), .setINTR(setINTR), .int_addr(int_addr), .int_id(int_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [1:0]   addr;
        logic [N-1:0] wdata;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [N-1:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [N-1:0] m);
        irq = irq | m;
        tick();
        irq = irq & ~m;
    endtask

    task automatic pulse_eoi;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic wait_jump(input int max, output int cyc, output logic found);
        found = 1'b0;
        for (cyc = 0; cyc <= max; cyc++) begin
            if (int_jump) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic watch_none(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (int_jump) cnt++;
        end
    endtask

    // Waits for a redirect, checks it, then plays the CPU: disable interrupts, one cycle on.
    task automatic expect_jump(input string name, input int id, input logic [31:0] addr,
                               output int cyc);
        logic found;
        wait_jump(12, cyc, found);
        check({name, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({name, "_id"}, 32'(int_id), 32'(id));
            check({name, "_addr"}, int_addr, addr);
            check({name, "_setintr"}, 32'(setINTR), 32'd1);
        end
        int_en_n = 1'b1;
        tick();
        check({name, "_one_cycle"}, 32'(int_jump), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] d;
        int           cyc;
        int           cnt;
        logic         found;

        vecs[0] = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 8'hFF};
        vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 2'd0, 8'hA5, 8'hA5};
        vecs[5] = '{1'b1, 2'd1, 8'h3C, 8'h3C};
        vecs[6] = '{1'b1, 2'd3, 8'hFF, 8'h00};
        vecs[7] = '{1'b1, 2'd2, 8'hFF, 8'h00};
        vecs[8] = '{1'b1, 2'd0, 8'h00, 8'h00};
        vecs[9] = '{1'b1, 2'd1, 8'hFF, 8'hFF};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_int_addr", int_addr, 32'h400);
        check("reset_int_id", 32'(int_id), 32'd0);
        check("reset_int_jump", 32'(int_jump), 32'd0);
        check("reset_setintr", 32'(setINTR), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            check($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), 32'(d), 32'(vecs[i].exp));
        end

        // Edge entry with minimum latency
        wr(2'd0, 8'h08);
        int_en_n = 1'b0;
        stop     = 1'b1;
        pulse_irq(8'h08);
        wait_jump(12, cyc, found);
        check("edge_latency", 32'(cyc), 32'd4);
        expect_jump("edge", 3, 32'h40C, cyc);
        rd(2'd2, d); check("edge_pending", 32'(d), 32'h00);
        rd(2'd3, d); check("edge_active", 32'(d), 32'h08);
        pulse_eoi();
        rd(2'd3, d); check("edge_active_eoi", 32'(d), 32'h00);

        // Priority: 2 beats 5, 5 blocked until 2 retires
        wr(2'd0, 8'hFF);
        int_en_n = 1'b0;
        pulse_irq(8'h24);
        expect_jump("prio_first", 2, 32'h408, cyc);
        int_en_n = 1'b0;
        watch_none(10, cnt);
        check("prio_blocked", 32'(cnt), 32'd0);
        rd(2'd2, d); check("prio_pending5", 32'(d), 32'h20);
        pulse_eoi();
        expect_jump("prio_second", 5, 32'h414, cyc);
        pulse_eoi();
        rd(2'd3, d); check("prio_active_clear", 32'(d), 32'h00);

        // Nesting over an active id 4
        int_en_n = 1'b0;
        pulse_irq(8'h10);
        expect_jump("nest_outer", 4, 32'h410, cyc);
        int_en_n = 1'b0;
        pulse_irq(8'h02);
        expect_jump("nest_inner", 1, 32'h404, cyc);
        rd(2'd3, d); check("nest_active", 32'(d), 32'h12);
        int_en_n = 1'b0;
        pulse_irq(8'h40);
        watch_none(10, cnt);
        check("nest_low_ignored", 32'(cnt), 32'd0);
        int_en_n = 1'b1;
        rd(2'd2, d); check("nest_pending6", 32'(d), 32'h40);
        pulse_eoi();
        rd(2'd3, d); check("nest_eoi1", 32'(d), 32'h10);
        pulse_eoi();
        rd(2'd3, d); check("nest_eoi2", 32'(d), 32'h00);
        wr(2'd2, 8'h40);
        rd(2'd2, d); check("nest_w1c", 32'(d), 32'h00);

        // Changing EDGE drops latched edge state
        wr(2'd0, 8'h00);
        pulse_irq(8'h04);
        repeat (3) tick();
        rd(2'd2, d); check("edgechg_latched", 32'(d), 32'h04);
        wr(2'd1, 8'hFB);
        wr(2'd1, 8'hFF);
        rd(2'd2, d); check("edgechg_cleared", 32'(d), 32'h00);

        // Level mode with mask gating and re-entry
        wr(2'd1, 8'h00);
        irq[0]   = 1'b1;
        int_en_n = 1'b0;
        stop     = 1'b1;
        watch_none(10, cnt);
        check("level_masked", 32'(cnt), 32'd0);
        rd(2'd2, d); check("level_pending", 32'(d), 32'h01);
        wr(2'd0, 8'h01);
        expect_jump("level_first", 0, 32'h400, cyc);
        rd(2'd2, d); check("level_still_pending", 32'(d), 32'h01);
        int_en_n = 1'b0;
        pulse_eoi();
        expect_jump("level_reenter", 0, 32'h400, cyc);
        irq[0] = 1'b0;
        pulse_eoi();
        rd(2'd3, d); check("level_active_clear", 32'(d), 32'h00);
        wr(2'd1, 8'hFF);

        // Abort from ARM by W1C
        wr(2'd0, 8'hFF);
        int_en_n = 1'b0;
        stop     = 1'b0;
        pulse_irq(8'h80);
        watch_none(5, cnt);
        check("abort_no_stop", 32'(cnt), 32'd0);
        wr(2'd2, 8'h80);
        stop = 1'b1;
        watch_none(10, cnt);
        check("abort_w1c", 32'(cnt), 32'd0);
        rd(2'd2, d); check("abort_pending", 32'(d), 32'h00);

        // Reset during ARM
        wr(2'd0, 8'h0F);
        stop = 1'b0;
        pulse_irq(8'h08);
        repeat (5) tick();
        rst_n = 1'b0;
        rd(2'd0, d); check("rst_async_mask", 32'(d), 32'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        stop  = 1'b1;
        watch_none(10, cnt);
        check("rst_no_pulse", 32'(cnt), 32'd0);
        rd(2'd1, d); check("rst_edge", 32'(d), 32'hFF);
        rd(2'd2, d); check("rst_pending", 32'(d), 32'h00);
        rd(2'd3, d); check("rst_active", 32'(d), 32'h00);
        check("rst_int_addr", int_addr, 32'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbscore_vic.md
# mbscore_vic

Parametrised vectored interrupt controller; successor to the single-line interrupt controller in the MBScore CPU top. Accepts `NUM_IRQ` external sources, synchronises them, latches them per-source as edge or level, applies a mask and fixed priority (index 0 highest), and redirects the CPU at an instruction boundary to a per-source vector. Supports nesting: a strictly higher-priority source may preempt an active handler once the CPU re-enables interrupts. It sits beside `MBScore_rf` and `MBScore_IR`, driving `int_jump`/`int_addr`/`setINTR` and exposing a small configuration port.

## Interface
- `NUM_IRQ`, 8: number of sources, 1..32.
- `ADDR_WIDTH`, 32: vector address width.
- `VEC_BASE`, 32'h0000_0400: address of vector 0.
- `VEC_SHIFT`, 2: vector n at `VEC_BASE + (n << VEC_SHIFT)`.
- `EDGE_RESET`, all-ones: reset value of the EDGE register.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq` in NUM_IRQ: raw asynchronous sources, active high.
- `int_en_n` in 1: CPU global disable; 1 = no new entries.
- `stop` in 1: CPU at instruction boundary, safe to redirect.
- `eoi` in 1: one-cycle end-of-interrupt pulse (handler return).
- `cfg_we` in 1; `cfg_addr` in 2; `cfg_wdata` in NUM_IRQ: register write.
- `cfg_rdata` out NUM_IRQ: combinational read of `cfg_addr`.
- `int_jump` out 1: one-cycle redirect pulse.
- `setINTR` out 1: asserted with `int_jump`; CPU sets `int_en_n`.
- `int_addr` out ADDR_WIDTH: vector of last taken interrupt, held.
- `int_id` out 5: index of last taken interrupt, held.

## Operation
- Sync: each `irq` bit through 2 flops (`s1`, `s2`), plus `s3` for edge detect.
- Registers (`cfg_addr`): 0 MASK rw (1 = enabled, reset 0); 1 EDGE rw (1 = edge, reset `EDGE_RESET`); 2 PENDING read, write-1-clears edge bits; 3 ACTIVE read-only. Writes to 3 ignored.
- PENDING[i]: edge mode set on `s2 & ~s3`, cleared by W1C or by taking i; level mode = `s2` directly (not writable, not cleared by taking).
- Same-cycle edge set and W1C on one bit: set wins.
- Threshold: index of lowest set ACTIVE bit, or NUM_IRQ if none. Eligible = PENDING & MASK & (index < threshold).
- Winner = lowest-index eligible bit.
- FSM: IDLE -> ARM when any eligible and `int_en_n`=0. ARM: winner re-evaluated every cycle; if none eligible or `int_en_n`=1 -> IDLE; if `stop`=1 -> TAKE. TAKE (one cycle): `int_jump`=`setINTR`=1, `int_addr`/`int_id` load winner captured on the ARM->TAKE edge, ACTIVE[id] set, edge PENDING[id] cleared; -> IDLE.
- `eoi`: clears lowest set ACTIVE bit; no effect if ACTIVE is 0. `eoi` in TAKE cycle: clear applies to prior ACTIVE, new bit still set.
- Changing EDGE for a bit clears its PENDING edge state on the same write.
- Reset: MASK=0, EDGE=`EDGE_RESET`, PENDING=ACTIVE=0, sync flops 0, FSM IDLE, `int_jump`=`setINTR`=0, `int_addr`=`VEC_BASE`, `int_id`=0. Reset mid-ARM/TAKE aborts with no pulse.

## Timing
- `irq` rising at edge k -> PENDING visible (cfg_rdata) after edge k+3 (edge mode) / k+2 (level).
- PENDING eligible -> ARM next edge; ARM with `stop`=1 -> `int_jump` high in the following cycle. Minimum irq-to-`int_jump`: 5 cycles.
- `int_jump`, `setINTR` exactly one cycle; never back-to-back (IDLE between).
- Config writes take effect next edge; `cfg_rdata` combinational.

## Test plan
- Reset: after `rst_n` release, `int_addr`=0x400, all outputs 0, `cfg_rdata` at addr 1 = 0xFF.
- Edge entry: MASK=0x08, pulse `irq[3]` 1 cycle, `int_en_n`=0, `stop`=1 -> one `int_jump`, `int_addr`=0x40C, `int_id`=3, PENDING=0, ACTIVE=0x08.
- Priority: `irq[5]` and `irq[2]` same cycle, MASK=0xFF -> first jump id 2; id 5 not taken while ACTIVE[2] set; after `eoi` and `int_en_n`=0 -> jump id 5, `int_addr`=0x414.
- Nesting: ACTIVE=0x10, `int_en_n`=0; `irq[1]` -> jump id 1, ACTIVE=0x12; `irq[6]` ignored; two `eoi` -> ACTIVE=0.
- Level/mask: EDGE=0, `irq[0]` held high, MASK=0 -> no jump, PENDING bit0=1; set MASK=1 -> jump to 0x400; after `eoi` and `int_en_n`=0 re-enters while level held.
- Abort/W1C: enter ARM with `stop`=0, write PENDING W1C -> FSM back to IDLE, no pulse; assert `rst_n`=0 during ARM -> no pulse, registers reset.
